// File: rtl/add_sub64_seq_pkg.sv
// Shared definitions for the sequential 64-bit add/subtract unit.
// Holds the operation encodings, the controller state enum and a small helper.
package add_sub64_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD64 = 2'b00,
        OP_ADC64 = 2'b01,
        OP_SUB64 = 2'b10,
        OP_RSB64 = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Subtract-type ops feed the adder with ~y and a forced carry-in of 1.
    function automatic logic op_inverts(input op_e o);
        return (o == OP_SUB64) || (o == OP_RSB64);
    endfunction

endpackage

// File: rtl/add_sub64_seq_add32_core.sv
// 32-bit combinational adder shared by the low and high word passes.
// Ports: x, y (addends), cin (carry-in), sum (result), cout (carry-out).
module add32_core (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] full;

    assign full = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    assign sum  = full[31:0];
    assign cout = full[32];

endmodule

// File: rtl/add_sub64_seq.sv
// Sequential 64-bit ADD/ADC/SUB/RSB built on one time-shared 32-bit adder.
// Ports: clk, rst (sync, active-high), start/op/a/b request; busy, done, s, n/z/c/v results.
module add_sub64_seq
    import add_sub64_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] s,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v
);

    state_e      state;
    op_e         op_in;
    op_e         op_r;
    logic [63:0] x_r;
    logic [63:0] y_r;
    logic        cin_sel;
    logic [31:0] s_lo;
    logic        k;
    logic        zlo;

    logic [63:0] y_eff;
    logic        cin_lo;
    logic        hi_sel;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    assign op_in = op_e'(op);

    // Operand conditioning: subtract-type ops add the one's complement.
    always_comb begin
        y_eff = op_inverts(op_r) ? ~y_r : y_r;
        unique case (op_r)
            OP_ADD64: cin_lo = 1'b0;
            OP_ADC64: cin_lo = cin_sel;
            OP_SUB64: cin_lo = 1'b1;
            OP_RSB64: cin_lo = 1'b1;
            default:  cin_lo = 1'b0;
        endcase
    end

    // Word select for the shared adder: low word in LO, high word in HI.
    always_comb begin
        hi_sel  = (state == ST_HI);
        add_x   = hi_sel ? x_r[63:32]   : x_r[31:0];
        add_y   = hi_sel ? y_eff[63:32] : y_eff[31:0];
        add_cin = hi_sel ? k            : cin_lo;
    end

    add32_core u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= 64'd0;
            n       <= 1'b0;
            z       <= 1'b0;
            c       <= 1'b0;
            v       <= 1'b0;
            op_r    <= OP_ADD64;
            x_r     <= 64'd0;
            y_r     <= 64'd0;
            cin_sel <= 1'b0;
            s_lo    <= 32'd0;
            k       <= 1'b0;
            zlo     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r    <= op_in;
                        // Reverse subtract swaps operands so it computes b - a.
                        x_r     <= (op_in == OP_RSB64) ? b : a;
                        y_r     <= (op_in == OP_RSB64) ? a : b;
                        cin_sel <= c;
                        busy    <= 1'b1;
                        state   <= ST_LO;
                    end
                end
                ST_LO: begin
                    s_lo  <= add_sum;
                    k     <= add_cout;
                    zlo   <= (add_sum == 32'd0);
                    state <= ST_HI;
                end
                ST_HI: begin
                    s     <= {add_sum, s_lo};
                    c     <= add_cout;
                    n     <= add_sum[31];
                    z     <= zlo & (add_sum == 32'd0);
                    v     <= (x_r[63] == y_eff[63]) & (add_sum[31] != x_r[63]);
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub64_seq.sv
// Self-checking bench for add_sub64_seq: directed vectors plus random ops.
// Results are compared with a wide-arithmetic reference model of the flags.
module tb_add_sub64_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] s;
    logic        n;
    logic        z;
    logic        c;
    logic        v;

    int n_checks;
    int n_fail;

    // Reference model state: architectural result and NZCV.
    logic [63:0] ms;
    logic        mn;
    logic        mz;
    logic        mc;
    logic        mv;

    add_sub64_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .n     (n),
        .z     (z),
        .c     (c),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arithmetic model: plain 64-bit modular result, carry as unsigned
    // carry / no-borrow, overflow from a 66-bit signed exact result.
    task automatic model_op(input logic [1:0] o, input logic [63:0] ai,
                            input logic [63:0] bi);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] sw;
        logic [64:0]        w;
        sa = {{2{ai[63]}}, ai};
        sb = {{2{bi[63]}}, bi};
        case (o)
            2'b00: begin
                w  = {1'b0, ai} + {1'b0, bi};
                sw = sa + sb;
            end
            2'b01: begin
                w  = {1'b0, ai} + {1'b0, bi} + {64'd0, mc};
                sw = sa + sb + $signed({65'd0, mc});
            end
            2'b10: begin
                w  = {(ai >= bi), ai - bi};
                sw = sa - sb;
            end
            default: begin
                w  = {(bi >= ai), bi - ai};
                sw = sb - sa;
            end
        endcase
        ms = w[63:0];
        mc = w[64];
        mn = ms[63];
        mz = (ms == 64'd0);
        mv = (sw[64] != sw[63]);
    endtask

    task automatic model_reset();
        ms = 64'd0;
        mn = 1'b0;
        mz = 1'b0;
        mc = 1'b0;
        mv = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_s"}, s, ms);
        check({tag, "_n"}, n, mn);
        check({tag, "_z"}, z, mz);
        check({tag, "_c"}, c, mc);
        check({tag, "_v"}, v, mv);
    endtask

    // Called at a negedge in IDLE. hold keeps start high (with junk
    // operands) through LO/HI/DONE; those requests must be ignored.
    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [63:0] ai, input logic [63:0] bi,
                         input bit hold);
        int          cyc;
        logic [63:0] prev_s;
        prev_s = ms;
        op     = o;
        a      = ai;
        b      = bi;
        start  = 1'b1;
        cyc    = 0;
        while (cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                op = 2'($urandom);
                a  = {$urandom, $urandom};
                b  = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            if (done) break;
            check({tag, "_s_hold"}, s, prev_s);
        end
        model_op(o, ai, bi);
        check({tag, "_latency"}, 64'(cyc), 64'd3);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b1);
        check_outputs(tag);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_s_keep"}, s, ms);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [1:0]  ro;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 64'd0;
        b     = 64'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check_outputs("rst");

        do_op("add_lo_carry", 2'b00, 64'h00000000_FFFFFFFF, 64'd1, 1'b0);
        check("add_lo_carry_const", s, 64'h00000001_00000000);

        do_op("sub_eq", 2'b10, 64'h12345678_9ABCDEF0,
              64'h12345678_9ABCDEF0, 1'b0);
        check("sub_eq_zc", {z, c}, 2'b11);
        do_op("sub_borrow", 2'b10, 64'd0, 64'd1, 1'b0);
        check("sub_borrow_const", s, 64'hFFFFFFFF_FFFFFFFF);

        do_op("add_ovf", 2'b00, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0);
        check("add_ovf_nv", {n, v}, 2'b11);

        do_op("add_wrap", 2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0);
        check("add_wrap_cz", {c, z}, 2'b11);
        do_op("adc_chain", 2'b01, 64'd0, 64'd0, 1'b0);
        check("adc_chain_const", s, 64'd1);

        do_op("rsb_hold", 2'b11, 64'd5, 64'd3, 1'b1);
        check("rsb_const", s, 64'hFFFFFFFF_FFFFFFFE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rsb_no_extra_done", done, 1'b0);
            check("rsb_s_unchanged", s, ms);
        end

        // Reset while the high word is being computed.
        op    = 2'b00;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_in_hi_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check_outputs("abort");
        @(negedge clk);
        check("abort_no_done", done, 1'b0);
        check("abort_still_idle", busy, 1'b0);

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_over_start", busy, 1'b0);

        do_op("after_abort", 2'b00, 64'h00000001_00000002,
              64'h00000003_00000004, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: ra[31:0] = 32'hFFFFFFFF;
                1: rb = ra;
                2: ra = 64'h80000000_00000000;
                3: rb = 64'hFFFFFFFF_FFFFFFFF;
                default: ;
            endcase
            do_op("rand", ro, ra, rb, (i % 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
